// File: rtl/regbank128_n_if.sv
// regbank128_n bus: write port, clear strobe, read handshake
// and the parallel entry array that feeds the 128:1 mux.
interface regbank128_n_if #(
  parameter int n = 4
);
  logic         wr_en_i;
  logic [6:0]   wr_addr_i;
  logic [n-1:0] wr_data_i;
  logic         clr_i;
  logic         rd_valid_i;
  logic [6:0]   rd_addr_i;
  logic         rd_ready_o;
  logic         rd_valid_o;
  logic [n-1:0] rd_data_o;
  logic         rd_ready_i;
  logic         busy_o;
  logic [n-1:0] data_o [128];

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i,
    output clr_i, rd_valid_i, rd_addr_i,
    output rd_ready_i,
    input  rd_ready_o, rd_valid_o, rd_data_o,
    input  busy_o, data_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i,
    input  clr_i, rd_valid_i, rd_addr_i,
    input  rd_ready_i,
    output rd_ready_o, rd_valid_o, rd_data_o,
    output busy_o, data_o
  );
endinterface

// File: rtl/regbank128_n.sv
// 128 x n register bank with registered read port,
// valid/ready handshake and a one-entry-per-cycle clear sweep.
module mux128to1_n #(
  parameter int n = 4
) (
  input  logic [n-1:0] data_i [128],
  input  logic [6:0]   sel,
  output logic [n-1:0] y
);
  assign y = data_i[sel];
endmodule

module regbank128_n #(
  parameter int n = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  regbank128_n_if.slave  bus
);
  localparam int address = 7;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [n-1:0]       mem [128];
  logic [0:0]         state;
  logic [address-1:0] cnt;
  logic [n-1:0]       mux_y;
  logic [n-1:0]       rd_data;
  logic               rd_valid;
  logic               busy;
  logic               rd_ready;
  logic               rd_acc;

  mux128to1_n #(.n(n)) u_mux (
    .data_i (mem),
    .sel    (bus.rd_addr_i),
    .y      (mux_y)
  );

  assign busy     = (state == CLEAR);
  assign rd_ready = !busy && (!rd_valid || bus.rd_ready_i);
  assign rd_acc   = bus.rd_valid_i && rd_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // clear takes priority over a same-cycle write
          if (bus.clr_i) begin
            state <= CLEAR;
            cnt   <= '0;
          end else if (bus.wr_en_i) begin
            mem[bus.wr_addr_i] <= bus.wr_data_i;
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          cnt      <= cnt + 1'b1;
          if (cnt == 7'd127) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_acc) begin
      rd_valid <= 1'b1;
      rd_data  <= mux_y;
    end else if (bus.rd_ready_i) begin
      rd_valid <= 1'b0;
    end
  end

  assign bus.rd_ready_o = rd_ready;
  assign bus.rd_valid_o = rd_valid;
  assign bus.rd_data_o  = rd_data;
  assign bus.busy_o     = busy;

  for (genvar g = 0; g < 128; g++) begin : g_out
    assign bus.data_o[g] = mem[g];
  end
endmodule

// File: tb/tb_regbank128_n.sv
// Directed bench for regbank128_n: vector table plus
// hand sequences for reset, clear sweep and mid-sweep reset.
module tb_regbank128_n;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  regbank128_n_if #(.n(4)) bus ();

  regbank128_n #(.n(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [6:0] wa;
    logic [3:0] wd;
    logic       rv;
    logic [6:0] ra;
    logic       rr;
    logic       e_rdy;
    logic       e_v;
    logic [3:0] e_d;
  } vec_t;

  vec_t tv [19];

  function automatic vec_t mk(
    logic we, logic [6:0] wa, logic [3:0] wd,
    logic rv, logic [6:0] ra, logic rr,
    logic e_rdy, logic e_v, logic [3:0] e_d
  );
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.rv = rv; v.ra = ra; v.rr = rr;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_d = e_d;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en_i    = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.clr_i      = 1'b0;
    bus.rd_valid_i = 1'b0;
    bus.rd_addr_i  = '0;
    bus.rd_ready_i = 1'b1;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  int busy_cnt;
  int rdy_bad;
  int nz;
  int cyc;

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_valid", bus.rd_valid_o, 0);
    chk("rst_data", bus.rd_data_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_ready", bus.rd_ready_o, 1);
    chk("rst_entry0", bus.data_o[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // async reset between edges
    @(negedge clk);
    bus.wr_en_i = 1'b1; bus.wr_addr_i = 7'd5; bus.wr_data_i = 4'hA;
    edge1();
    chk("wr5", bus.data_o[5], 4'hA);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_entry5", bus.data_o[5], 0);
    chk("arst_valid", bus.rd_valid_o, 0);
    chk("arst_busy", bus.busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    tv[0]  = mk(1, 0,   4'h3, 0, 0,   1, 1, 0, 4'h0);
    tv[1]  = mk(1, 64,  4'h7, 0, 0,   1, 1, 0, 4'h0);
    tv[2]  = mk(1, 127, 4'hC, 0, 0,   1, 1, 0, 4'h0);
    tv[3]  = mk(1, 10,  4'h2, 0, 0,   1, 1, 0, 4'h0);
    tv[4]  = mk(0, 0,   4'h0, 1, 127, 1, 1, 1, 4'hC);
    tv[5]  = mk(0, 0,   4'h0, 1, 64,  1, 1, 1, 4'h7);
    tv[6]  = mk(0, 0,   4'h0, 1, 0,   1, 1, 1, 4'h3);
    tv[7]  = mk(0, 0,   4'h0, 0, 0,   1, 1, 0, 4'h3);
    tv[8]  = mk(0, 0,   4'h0, 1, 64,  0, 1, 1, 4'h7);
    for (int i = 9; i < 14; i++)
      tv[i] = mk(0, 0, 4'h0, 1, 0, 0, 0, 1, 4'h7);
    tv[14] = mk(0, 0,   4'h0, 1, 0,   1, 1, 1, 4'h3);
    tv[15] = mk(0, 0,   4'h0, 0, 0,   1, 1, 0, 4'h3);
    tv[16] = mk(1, 10,  4'h9, 1, 10,  1, 1, 1, 4'h2);
    tv[17] = mk(0, 0,   4'h0, 1, 10,  1, 1, 1, 4'h9);
    tv[18] = mk(0, 0,   4'h0, 0, 0,   1, 1, 0, 4'h9);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      bus.wr_en_i    = tv[i].we;
      bus.wr_addr_i  = tv[i].wa;
      bus.wr_data_i  = tv[i].wd;
      bus.rd_valid_i = tv[i].rv;
      bus.rd_addr_i  = tv[i].ra;
      bus.rd_ready_i = tv[i].rr;
      #1;
      chk($sformatf("v%0d_ready", i), bus.rd_ready_o, tv[i].e_rdy);
      edge1();
      chk($sformatf("v%0d_valid", i), bus.rd_valid_o, tv[i].e_v);
      chk($sformatf("v%0d_data", i), bus.rd_data_o, tv[i].e_d);
      if (tv[i].we)
        chk($sformatf("v%0d_entry", i), bus.data_o[tv[i].wa], tv[i].wd);
    end

    // fill with 0xF, then clear with a same-edge read
    for (int a = 0; a < 128; a++) begin
      @(negedge clk);
      idle();
      bus.wr_en_i = 1'b1;
      bus.wr_addr_i = 7'(a);
      bus.wr_data_i = 4'hF;
    end
    @(negedge clk);
    idle();
    chk("fill_entry77", bus.data_o[77], 4'hF);
    bus.clr_i = 1'b1;
    bus.rd_valid_i = 1'b1;
    bus.rd_addr_i = 7'd5;
    edge1();
    chk("clr_busy", bus.busy_o, 1);
    chk("clr_rd_valid", bus.rd_valid_o, 1);
    chk("clr_rd_preclear", bus.rd_data_o, 4'hF);
    busy_cnt = 0;
    rdy_bad  = 0;
    cyc      = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      idle();
      if (!bus.busy_o) break;
      busy_cnt++;
      bus.rd_ready_i = 1'b0;
      bus.rd_valid_i = 1'b1;
      bus.rd_addr_i  = 7'd3;
      #1;
      if (bus.rd_ready_o) rdy_bad++;
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = 7'(busy_cnt);
      bus.wr_data_i = 4'h5;
      bus.clr_i     = (busy_cnt == 50);
    end
    chk("sweep_len", busy_cnt, 128);
    chk("sweep_ready_low", rdy_bad, 0);
    chk("sweep_hold_valid", bus.rd_valid_o, 1);
    chk("sweep_hold_data", bus.rd_data_o, 4'hF);
    nz = 0;
    for (int a = 0; a < 128; a++)
      if (bus.data_o[a] != 4'h0) nz++;
    chk("sweep_all_zero", nz, 0);
    edge1();
    chk("sweep_drain", bus.rd_valid_o, 0);
    chk("sweep_idle", bus.busy_o, 0);

    // reset in the middle of a sweep
    @(negedge clk);
    idle();
    bus.wr_en_i = 1'b1; bus.wr_addr_i = 7'd120; bus.wr_data_i = 4'hB;
    @(negedge clk);
    idle();
    bus.rd_ready_i = 1'b0;
    bus.rd_valid_i = 1'b1; bus.rd_addr_i = 7'd120;
    @(negedge clk);
    idle();
    bus.rd_ready_i = 1'b0;
    bus.clr_i = 1'b1;
    edge1();
    chk("ms_pending", bus.rd_data_o, 4'hB);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      idle();
      bus.rd_ready_i = 1'b0;
    end
    chk("ms_busy_before", bus.busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ms_busy", bus.busy_o, 0);
    chk("ms_valid", bus.rd_valid_o, 0);
    chk("ms_data", bus.rd_data_o, 0);
    chk("ms_entry120", bus.data_o[120], 0);
    chk("ms_ready", bus.rd_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    bus.wr_en_i = 1'b1; bus.wr_addr_i = 7'd100; bus.wr_data_i = 4'h6;
    edge1();
    chk("ms_busy_after", bus.busy_o, 0);
    @(negedge clk);
    idle();
    bus.rd_valid_i = 1'b1; bus.rd_addr_i = 7'd100;
    edge1();
    chk("ms_rd_valid", bus.rd_valid_o, 1);
    chk("ms_rd_data", bus.rd_data_o, 4'h6);
    @(negedge clk);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
